// File: rtl/mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: HI/LO op encodings,
// default latencies and the MDU state type. The controller imports the same package.
package mdu_pkg;

  // MDU operation encodings carried on the 4-bit op field
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;

  // Default busy durations
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    StIdle,
    StRun
  } mdu_state_e;

  // True for the ops that occupy the unit for several cycles
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit. Results are computed combinationally at the start
// edge and latched; HI/LO are committed only when the busy countdown expires, so the
// pipeline sees the MIPS-style multi-cycle latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HILO_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Declaration initialisers keep everything at zero before the first reset
  mdu_state_e  state_q     = StIdle;
  logic        busy_q      = 1'b0;
  logic [3:0]  cnt_q       = 4'd0;
  logic [31:0] hi_q        = 32'd0;
  logic [31:0] lo_q        = 32'd0;
  logic [31:0] res_hi_q    = 32'd0;
  logic [31:0] res_lo_q    = 32'd0;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;
  logic [3:0]  cnt_load;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Result of the long op presented this cycle; divide by zero re-latches HI/LO so
  // the commit at the end of the countdown leaves them unchanged.
  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    cnt_load = 4'(DIV_CYCLES);
    case (op)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
        cnt_load = 4'(MULT_CYCLES);
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
        cnt_load = 4'(MULT_CYCLES);
      end
      OP_DIV: begin
        if (B == 32'd0) begin
          res_hi_d = hi_q;
          res_lo_d = lo_q;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // Overflow case: quotient wraps, remainder is zero
          res_hi_d = 32'd0;
          res_lo_d = 32'h8000_0000;
        end else begin
          res_hi_d = $signed(A) % $signed(B);
          res_lo_d = $signed(A) / $signed(B);
        end
      end
      OP_DIVU: begin
        if (B != 32'd0) begin
          res_hi_d = A % B;
          res_lo_d = A / B;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered busy; HI/LO writes from MTHI/MTLO or countdown expiry
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (is_long_op(op)) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              cnt_q    <= cnt_load;
              state_q  <= StRun;
              busy_q   <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        StRun: begin
          // start is ignored here; the hazard unit stalls MDU ops while busy
          if (cnt_q == 4'd1) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            cnt_q   <= 4'd0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read port for MFHI/MFLO, independent of start
  always_comb begin
    HILO_out = 32'd0;
    case (op)
      OP_MFHI: HILO_out = hi_q;
      OP_MFLO: HILO_out = lo_q;
      default: HILO_out = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: table of long ops with hand-computed results pushed to a
// scoreboard at launch and popped when busy falls, plus hand-written corner sequences.
module tb_mdu;
  import mdu_pkg::*;

  localparam logic [3:0] OP_NONE = 4'hF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests;
  int failed;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  mdu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .HILO_out (HILO_out),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one op for a single edge, then return the inputs to a neutral op
  task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NONE;
  endtask

  // Count busy cycles at negedges; returns at the first negedge with busy low
  task automatic measure(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic score(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      check({e.name, "_cycles"}, 32'(n), 32'(e.cycles));
      check({e.name, "_hi"}, HI, e.hi);
      check({e.name, "_lo"}, LO, e.lo);
      op = OP_MFHI;
      #1 check({e.name, "_mfhi"}, HILO_out, e.hi);
      op = OP_MFLO;
      #1 check({e.name, "_mflo"}, HILO_out, e.lo);
      op = OP_NONE;
    end
  endtask

  initial begin
    int   n;
    logic late_ok;
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = OP_NONE;
    A      = 32'd0;
    B      = 32'd0;

    vecs[0] = '{"mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,
                32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,
                32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu_zero",  OP_DIVU,  32'd7,         32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{"divu_big",   OP_DIVU,  32'hFFFF_FFF9, 32'd2,
                32'h0000_0001, 32'h7FFF_FFFC, 10};
    vecs[6] = '{"mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 32'h0000_0000, 5};
    vecs[7] = '{"div_negdiv", OP_DIV,   32'd7,         32'hFFFF_FFFE,
                32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[8] = '{"multu_2p32", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
                32'h0000_0001, 32'h0000_0000, 5};
    vecs[9] = '{"div_zero",   OP_DIV,   32'd0,         32'd0,
                32'h0000_0001, 32'h0000_0000, 10};

    // Power-on state before any reset
    #1;
    check("pre_reset_busy", 32'(busy), 32'd0);
    check("pre_reset_hi", HI, 32'd0);
    check("pre_reset_lo", LO, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;

    // Table-driven long ops
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].cycles});
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      measure(n);
      score(n);
    end

    // MTHI then MFHI next cycle, no busy
    launch(OP_MTHI, 32'h1234_5678, 32'd0);
    start = 1'b1;
    op    = OP_MFHI;
    #1 check("mthi_mfhi", HILO_out, 32'h1234_5678);
    @(negedge clk);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mfhi_lo_kept", LO, 32'h0000_0000);
    start = 1'b0;
    launch(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_lo", LO, 32'hCAFE_F00D);
    check("mtlo_hi_kept", HI, 32'h1234_5678);

    // Unknown op is a no-op
    launch(4'hE, 32'h5555_5555, 32'h3);
    @(negedge clk);
    check("unk_busy", 32'(busy), 32'd0);
    check("unk_hi", HI, 32'h1234_5678);
    check("unk_lo", LO, 32'hCAFE_F00D);

    // DIV with a MULT start on busy cycle 3, which must be ignored
    sb.push_back('{"div_ign", 32'd2, 32'd14, 10});
    launch(OP_DIV, 32'd100, 32'd7);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 3) begin
        start = 1'b1;
        op    = OP_MULT;
        A     = 32'd3;
        B     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NONE;
      end
    end
    score(n);

    // Reset at busy cycle 2 of a MULT aborts it
    launch(OP_MULT, 32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    late_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || HI != 32'd0 || LO != 32'd0) late_ok = 1'b0;
    end
    check("abort_no_late_write", 32'(late_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of a divide.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU operation; sampled at posedge.
REQ-006 SHALL have port op  input  4  MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 SHALL have port A  input  32  forwarded rs value.
REQ-008 SHALL have port B  input  32  forwarded rt value.
REQ-009 SHALL have port busy  output  1  multiply/divide in progress.
REQ-010 SHALL have port HILO_out  output  32  MFHI/MFLO read data to the E/M register HILO field.
REQ-011 SHALL have port HI  output  32  architectural HI, for debug.
REQ-012 SHALL have port LO  output  32  architectural LO, for debug.

Function
REQ-013 SHALL have two states: IDLE (busy=0) and RUN (busy=1) with a down-counter cnt of 4 bits.
REQ-014 SHALL, in IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}, latch result_hi/result_lo, go to RUN and load cnt=MULT_CYCLES or DIV_CYCLES.
REQ-015 SHALL hold busy=1 for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge.
REQ-016 SHALL decrement cnt each edge in RUN, and at the edge where cnt==1 write HI/LO from the latched results and return to IDLE.
REQ-017 SHALL make new HI/LO visible in the first cycle with busy=0.
REQ-018 SHALL compute MULT as the signed 64-bit product and MULTU as the unsigned 64-bit product: HI = bits 63:32, LO = bits 31:0.
REQ-019 SHALL compute DIV and DIVU as LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU is unsigned.
REQ-020 SHALL handle signed DIV of 0x80000000 by 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-021 SHALL, on divide by zero (B=0), still run DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-022 SHALL ignore start while busy=1; the hazard unit is required to stall any MDU instruction while busy=1.
REQ-023 SHALL, in IDLE with start=1 and op=MTHI (or MTLO), write A to HI (or LO) at that edge with no busy cycles.
REQ-024 SHALL drive HILO_out combinationally: HI when op=MFHI, LO when op=MFLO, otherwise 0; it does not depend on start.
REQ-025 SHALL leave HI/LO unchanged on MFHI/MFLO.
REQ-026 SHALL treat an unknown op with start=1 as a no-op.

Reset
REQ-027 SHALL, when reset=0 at posedge, clear HI, LO, result_hi, result_lo and cnt to 0, set state IDLE and busy=0.
REQ-028 SHALL, on reset mid-RUN, abort the operation; no HI/LO write occurs after reset.
REQ-029 SHALL hold all registers at 0 from time zero until the first reset.

Structure
REQ-030 SHALL take the op encodings (4-bit constants) and the default latencies 5/10 from the shared CPU definitions package, which the controller also uses.
REQ-031 SHALL have no sub-module; multiply and divide are behavioural operators feeding the result latches.
REQ-032 SHALL be instantiated in the E stage, with HILO_out wired to HILO_in of the E/M pipeline register.

Verification
REQ-033 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-035 SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-036 SHALL cover: MTHI A=0x12345678, then MFHI the next cycle -> HILO_out=0x12345678 with busy never asserted.
REQ-037 SHALL cover: DIV started, second start (MULT) at busy cycle 3 -> ignored; results are the DIV results only, busy falls after exactly 10 cycles.
REQ-038 SHALL cover: MULT started, reset=0 at busy cycle 2 -> busy=0 next cycle, HI=LO=0, and no late write appears in the following 10 cycles.
